// File: rtl/adc_spi_responder.sv
// adc_spi_responder
//   Takes channel requests on an Avalon-ST style command sink and runs SPI
//   frames on an 8-channel, 12-bit, address-pipelined ADC. The converter
//   returns the channel addressed in the previous frame. When the requested
//   channel differs from the last address sent, a priming frame runs first
//   and its data is discarded. One response strobe is issued per command.
//   Channels above 7 are answered at once with zero data and no SPI frame.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   cmd_valid / cmd_ready        command handshake (cmd_ready high only in IDLE)
//   cmd_channel[4:0]             requested channel
//   cmd_startofpacket/endofpacket  framing flags, echoed on the response
//   rsp_valid                    one-cycle response strobe, no backpressure
//   rsp_data[11:0], rsp_channel[4:0], rsp_startofpacket, rsp_endofpacket
//   adc_cs_n, adc_sclk, adc_din  SPI outputs (SCLK idles high)
//   adc_dout                     SPI data from the converter
module adc_spi_responder #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [4:0] cmd_channel,
    input  logic       cmd_startofpacket,
    input  logic       cmd_endofpacket,
    output logic       rsp_valid,
    output logic [11:0] rsp_data,
    output logic [4:0] rsp_channel,
    output logic       rsp_startofpacket,
    output logic       rsp_endofpacket,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    output logic       adc_din,
    input  logic       adc_dout
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, RESP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state, state_nxt;
    logic [7:0]  div_cnt, div_nxt;
    logic [3:0]  bit_cnt, bit_nxt;
    logic        half, half_nxt;        // 0: SCLK low half, 1: SCLK high half
    logic        prime, prime_nxt;      // current frame only primes the address
    logic [2:0]  last_addr, last_addr_nxt;
    logic [11:0] shreg, shreg_nxt;
    logic [4:0]  cap_ch;
    logic        cap_sop, cap_eop;

    logic        handshake;
    logic        div_done;

    logic        cs_n_nxt, sclk_nxt, din_nxt, ready_nxt, rvalid_nxt;
    logic [11:0] rdata_nxt;
    logic [4:0]  rch_nxt;
    logic        rsop_nxt, reop_nxt;

    assign handshake = (state == IDLE) && cmd_valid && cmd_ready;
    assign div_done  = (div_cnt == DIV_LAST);

    // State register, counters, capture and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            div_cnt           <= '0;
            bit_cnt           <= '0;
            half              <= 1'b0;
            prime             <= 1'b0;
            last_addr         <= '0;
            shreg             <= '0;
            cap_ch            <= '0;
            cap_sop           <= 1'b0;
            cap_eop           <= 1'b0;
            adc_cs_n          <= 1'b1;
            adc_sclk          <= 1'b1;
            adc_din           <= 1'b0;
            cmd_ready         <= 1'b0;
            rsp_valid         <= 1'b0;
            rsp_data          <= '0;
            rsp_channel       <= '0;
            rsp_startofpacket <= 1'b0;
            rsp_endofpacket   <= 1'b0;
        end else begin
            state             <= state_nxt;
            div_cnt           <= div_nxt;
            bit_cnt           <= bit_nxt;
            half              <= half_nxt;
            prime             <= prime_nxt;
            last_addr         <= last_addr_nxt;
            shreg             <= shreg_nxt;
            if (handshake) begin
                cap_ch  <= cmd_channel;
                cap_sop <= cmd_startofpacket;
                cap_eop <= cmd_endofpacket;
            end
            adc_cs_n          <= cs_n_nxt;
            adc_sclk          <= sclk_nxt;
            adc_din           <= din_nxt;
            cmd_ready         <= ready_nxt;
            rsp_valid         <= rvalid_nxt;
            rsp_data          <= rdata_nxt;
            rsp_channel       <= rch_nxt;
            rsp_startofpacket <= rsop_nxt;
            rsp_endofpacket   <= reop_nxt;
        end
    end

    // Next-state and sequencing counters
    always_comb begin
        state_nxt     = state;
        div_nxt       = div_cnt;
        bit_nxt       = bit_cnt;
        half_nxt      = half;
        prime_nxt     = prime;
        last_addr_nxt = last_addr;
        shreg_nxt     = shreg;
        case (state)
            IDLE: begin
                if (handshake) begin
                    div_nxt = '0;
                    if (cmd_channel[4:3] != 2'b00) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = SETUP;
                        prime_nxt = (cmd_channel[2:0] != last_addr);
                    end
                end
            end
            SETUP: begin
                if (div_done) begin
                    state_nxt = SHIFT;
                    div_nxt   = '0;
                    bit_nxt   = '0;
                    half_nxt  = 1'b0;
                end else begin
                    div_nxt = div_cnt + 8'd1;
                end
            end
            SHIFT: begin
                if (div_done) begin
                    div_nxt = '0;
                    if (!half) begin
                        half_nxt = 1'b1;
                    end else begin
                        // Last clk of the high half: sample DOUT, data bits are 4..15
                        if (bit_cnt >= 4'd4) begin
                            shreg_nxt = {shreg[10:0], adc_dout};
                        end
                        half_nxt = 1'b0;
                        if (bit_cnt == 4'd15) begin
                            state_nxt     = GAP;
                            last_addr_nxt = cap_ch[2:0];
                        end else begin
                            bit_nxt = bit_cnt + 4'd1;
                        end
                    end
                end else begin
                    div_nxt = div_cnt + 8'd1;
                end
            end
            GAP: begin
                if (div_done) begin
                    div_nxt = '0;
                    if (prime) begin
                        state_nxt = SETUP;
                        prime_nxt = 1'b0;
                    end else begin
                        state_nxt = RESP;
                    end
                end else begin
                    div_nxt = div_cnt + 8'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output next values, registered above so the pins are glitch-free
    always_comb begin
        cs_n_nxt   = !((state_nxt == SETUP) || (state_nxt == SHIFT));
        sclk_nxt   = !((state_nxt == SHIFT) && !half_nxt);
        din_nxt    = adc_din;
        ready_nxt  = (state_nxt == IDLE);
        rvalid_nxt = (state_nxt == RESP);
        rdata_nxt  = rsp_data;
        rch_nxt    = rsp_channel;
        rsop_nxt   = rsp_startofpacket;
        reop_nxt   = rsp_endofpacket;

        if (state_nxt == SETUP) begin
            din_nxt = 1'b0;
        end else if ((state_nxt == SHIFT) && !half_nxt && (div_nxt == 8'd0)) begin
            // SCLK falling edge: present the next frame bit
            case (bit_nxt)
                4'd2:    din_nxt = cap_ch[2];
                4'd3:    din_nxt = cap_ch[1];
                4'd4:    din_nxt = cap_ch[0];
                default: din_nxt = 1'b0;
            endcase
        end

        if (state_nxt == RESP) begin
            if (state == IDLE) begin
                // Out-of-range channel: answered straight from the command beat
                rdata_nxt = '0;
                rch_nxt   = cmd_channel;
                rsop_nxt  = cmd_startofpacket;
                reop_nxt  = cmd_endofpacket;
            end else begin
                rdata_nxt = shreg;
                rch_nxt   = cap_ch;
                rsop_nxt  = cap_sop;
                reop_nxt  = cap_eop;
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_responder.sv
module tb_adc_spi_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // DUT0: CLK_DIV = 4
    logic        cmd_valid, cmd_ready, cmd_sop, cmd_eop;
    logic [4:0]  cmd_channel;
    logic        rsp_valid, rsp_sop, rsp_eop;
    logic [11:0] rsp_data;
    logic [4:0]  rsp_channel;
    logic        cs_n0, sclk0, din0, dout0;

    // DUT1: CLK_DIV = 1
    logic        cmd1_valid, cmd1_ready;
    logic [4:0]  cmd1_channel;
    logic        rsp1_valid, rsp1_sop, rsp1_eop;
    logic [11:0] rsp1_data;
    logic [4:0]  rsp1_channel;
    logic        cs_n1, sclk1, din1, dout1;

    logic [11:0] mem [2][8];

    int n_chk = 0;
    int n_bad = 0;

    adc_spi_responder #(.CLK_DIV(4)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_channel(cmd_channel),
        .cmd_startofpacket(cmd_sop), .cmd_endofpacket(cmd_eop),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_channel(rsp_channel),
        .rsp_startofpacket(rsp_sop), .rsp_endofpacket(rsp_eop),
        .adc_cs_n(cs_n0), .adc_sclk(sclk0), .adc_din(din0), .adc_dout(dout0)
    );

    adc_spi_responder #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd1_valid), .cmd_ready(cmd1_ready), .cmd_channel(cmd1_channel),
        .cmd_startofpacket(1'b1), .cmd_endofpacket(1'b1),
        .rsp_valid(rsp1_valid), .rsp_data(rsp1_data), .rsp_channel(rsp1_channel),
        .rsp_startofpacket(rsp1_sop), .rsp_endofpacket(rsp1_eop),
        .adc_cs_n(cs_n1), .adc_sclk(sclk1), .adc_din(din1), .adc_dout(dout1)
    );

    // Converter model per bus: returns the channel addressed in the previous
    // complete frame; DOUT changes shortly after each SCLK fall.
    for (genvar g = 0; g < 2; g++) begin : g_bfm
        logic cs, sck, sdi;
        logic d_q = 1'b0;
        int frames = 0;
        int icnt = 0;
        int ocnt = 0;
        logic [15:0] oword = '0;
        logic [15:0] din_sh = '0;
        logic [15:0] din_word = '0;
        logic [2:0]  prev = '0;
        longint last_fall = -1;
        longint per = 0;

        assign cs  = (g == 0) ? cs_n0 : cs_n1;
        assign sck = (g == 0) ? sclk0 : sclk1;
        assign sdi = (g == 0) ? din0  : din1;

        always @(negedge cs) begin
            frames++;
            icnt = 0;
            ocnt = 0;
            din_sh = '0;
            last_fall = -1;
            oword = {4'b1010, mem[g][prev]};
        end

        always @(negedge sck) begin
            if (!cs) begin
                if (last_fall >= 0) per = longint'($time) - last_fall;
                last_fall = longint'($time);
                #1;
                if (ocnt < 16) d_q = oword[15 - ocnt];
                ocnt++;
            end
        end

        always @(posedge sck) begin
            if (!cs) begin
                din_sh = {din_sh[14:0], sdi};
                icnt++;
            end
        end

        always @(posedge cs) begin
            if (icnt == 16) begin
                din_word = din_sh;
                prev = din_sh[13:11];
            end
        end
    end

    assign dout0 = g_bfm[0].d_q;
    assign dout1 = g_bfm[1].d_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_cmd(input logic [4:0] ch, input logic sop, input logic eop,
                          input int exp_lat, input logic [11:0] exp_data, input int exp_frames);
        int f0;
        int k;
        int ready_hi;
        int w;
        bit got;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) check("ready_timeout", 0, 1);
        f0 = g_bfm[0].frames;
        cmd_valid   = 1'b1;
        cmd_channel = ch;
        cmd_sop     = sop;
        cmd_eop     = eop;
        @(posedge clk);
        @(negedge clk);
        // Fields change while not ready; must be ignored
        cmd_channel = ~ch;
        cmd_sop     = ~sop;
        cmd_eop     = ~eop;
        k = 1;
        ready_hi = 0;
        got = 0;
        while (k <= 400) begin
            if (rsp_valid) begin
                got = 1;
                break;
            end
            if (cmd_ready) ready_hi++;
            @(negedge clk);
            k++;
        end
        cmd_valid = 1'b0;
        if (!got) begin
            check("rsp_timeout", 0, 1);
            return;
        end
        check("latency", k, exp_lat);
        check("rsp_data", rsp_data, exp_data);
        check("rsp_channel", rsp_channel, ch);
        check("rsp_sop", rsp_sop, sop);
        check("rsp_eop", rsp_eop, eop);
        check("frames", g_bfm[0].frames - f0, exp_frames);
        check("ready_busy", ready_hi, 0);
        if (exp_frames > 0) check("din_word", g_bfm[0].din_word, {2'b00, ch[2:0], 11'b0});
        @(negedge clk);
        check("rsp_pulse", rsp_valid, 0);
        check("rsp_hold", rsp_data, exp_data);
        check("ready_after", cmd_ready, 1);
    endtask

    initial begin
        int w;
        int k;
        bit got;
        for (int i = 0; i < 8; i++) begin
            mem[0][i] = 12'h111 * 12'(i);
            mem[1][i] = 12'h000;
        end
        mem[0][0] = 12'hABC;
        mem[0][5] = 12'h123;
        mem[1][0] = 12'h5A3;

        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_channel = '0; cmd_sop = 1'b0; cmd_eop = 1'b0;
        cmd1_valid = 1'b0; cmd1_channel = '0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", cs_n0, 1);
        check("rst_sclk", sclk0, 1);
        check("rst_din", din0, 0);
        check("rst_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_ch", rsp_channel, 0);
        check("rst_rsp_sop_eop", {rsp_sop, rsp_eop}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_post_rst", cmd_ready, 1);

        do_cmd(5'd0, 1'b1, 1'b1, 137, 12'hABC, 1);
        do_cmd(5'd5, 1'b1, 1'b1, 273, 12'h123, 2);
        do_cmd(5'd5, 1'b1, 1'b1, 137, 12'h123, 1);
        for (int i = 0; i < 8; i++)
            do_cmd(5'(i), (i == 0), (i == 7), 273, mem[0][i], 2);
        check("sclk_period_div4", 32'(g_bfm[0].per), 80);

        do_cmd(5'd0, 1'b1, 1'b1, 273, 12'hABC, 2);
        do_cmd(5'd9, 1'b0, 1'b1, 1, 12'h000, 0);
        do_cmd(5'd0, 1'b1, 1'b0, 137, 12'hABC, 1);

        // Reset in the middle of SHIFT bit 7
        @(negedge clk);
        cmd_valid = 1'b1; cmd_channel = 5'd0; cmd_sop = 1'b1; cmd_eop = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        w = 0;
        while (!(g_bfm[0].icnt == 7 && sclk0 == 1'b0) && w < 400) begin
            @(negedge clk);
            w++;
        end
        check("reach_bit7", (g_bfm[0].icnt == 7 && sclk0 == 1'b0), 1);
        reset_n = 1'b0;
        #1;
        check("abort_cs_n", cs_n0, 1);
        check("abort_sclk", sclk0, 1);
        check("abort_rsp", rsp_valid, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("abort_ready", cmd_ready, 1);
        check("abort_no_rsp", rsp_valid, 0);
        do_cmd(5'd3, 1'b1, 1'b1, 273, mem[0][3], 2);

        // CLK_DIV = 1 instance
        @(negedge clk);
        cmd1_valid = 1'b1; cmd1_channel = 5'd0;
        @(posedge clk);
        @(negedge clk);
        cmd1_valid = 1'b0;
        k = 1;
        got = 0;
        while (k <= 100) begin
            if (rsp1_valid) begin
                got = 1;
                break;
            end
            @(negedge clk);
            k++;
        end
        if (!got) begin
            check("div1_timeout", 0, 1);
        end else begin
            check("div1_latency", k, 35);
            check("div1_data", rsp1_data, 12'h5A3);
            check("div1_channel", rsp1_channel, 0);
            check("div1_frames", g_bfm[1].frames, 1);
            check("div1_sclk_period", 32'(g_bfm[1].per), 20);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_spi_responder.md
ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 Parameter: CLK_DIV, 4, clk cycles per SCLK half-period (legal 1..255).
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command beat valid (Avalon-ST sink).
REQ-005 cmd_ready  output  1  command beat accepted when cmd_valid & cmd_ready.
REQ-006 cmd_channel  input  5  requested ADC channel.
REQ-007 cmd_startofpacket  input  1  first command of a sequence.
REQ-008 cmd_endofpacket  input  1  last command of a sequence.
REQ-009 rsp_valid  output  1  one-cycle response strobe; no backpressure.
REQ-010 rsp_data  output  12  conversion result.
REQ-011 rsp_channel  output  5  channel of this result.
REQ-012 rsp_startofpacket  output  1  echo of captured cmd_startofpacket.
REQ-013 rsp_endofpacket  output  1  echo of captured cmd_endofpacket.
REQ-014 adc_cs_n  output  1  SPI chip select, active low.
REQ-015 adc_sclk  output  1  SPI clock, idles high.
REQ-016 adc_din  output  1  SPI data to ADC.
REQ-017 adc_dout  input  1  SPI data from ADC (8-ch, 12-bit, address-pipelined converter).

Function
REQ-018 States SHALL be IDLE, SETUP, SHIFT, GAP, RESP; cmd_ready registered, high only in IDLE.
REQ-019 Handshake in IDLE SHALL capture channel, sop, eop; cmd_ready drops the next cycle.
REQ-020 Channel > 7: no SPI frame; next state RESP with rsp_data=0; last_addr unchanged.
REQ-021 Frame: SETUP = adc_cs_n low, adc_sclk high, CLK_DIV cycles; SHIFT = 16 SCLK periods, each CLK_DIV low then CLK_DIV high; GAP = adc_cs_n high, CLK_DIV cycles.
REQ-022 adc_din SHALL change only at SCLK falling edges (and SETUP entry); frame bits MSB first, bits 2..4 = channel[2:0] MSB first, all others 0.
REQ-023 adc_dout SHALL be sampled in the last clk of each SCLK high half; bits 4..15 form rsp_data[11:0] MSB first; bits 0..3 ignored.
REQ-024 Converter returns the channel addressed in the previous frame; block SHALL hold last_addr (reset 0).
REQ-025 If captured channel != last_addr, a priming frame (same DIN address) SHALL run first, its data discarded, then the real frame; else real frame only.
REQ-026 After each frame last_addr SHALL equal the DIN address sent.
REQ-027 Latency, handshake at cycle T: rsp_valid high exactly at T+1+34*CLK_DIV (no priming), T+1+68*CLK_DIV (primed), T+1 (channel > 7).
REQ-028 RESP lasts one cycle; rsp_* fields SHALL hold their values until the next RESP; IDLE (cmd_ready=1) follows.
REQ-029 cmd_valid deasserting or fields changing while cmd_ready=0 SHALL have no effect.
REQ-030 Packet framing SHALL NOT alter timing; sop/eop are echoed only.

Reset
REQ-031 On reset_n low, immediately and asynchronously: adc_cs_n=1, adc_sclk=1, adc_din=0, cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_channel=0, rsp_sop=0, rsp_eop=0, last_addr=0, state=IDLE.
REQ-032 Reset mid-frame SHALL abort it with no response; cmd_ready SHALL be 1 in the first cycle after release.

Verification (CLK_DIV=4 unless stated; ADC bus-functional model)
REQ-033 Reset, cmd ch0 sop=eop=1, model data 0xABC -> one frame, DIN all 0, rsp at T+137: data 0xABC, ch0, sop=eop=1.
REQ-034 Then cmd ch5, model 0x123 -> two frames with DIN bits2..4=101, rsp at T+273 with 0x123, ch5; repeat ch5 -> one frame, T+137.
REQ-035 Packet ch0..7, sop first/eop last only -> 8 responses in order, framing echoed, cmd_ready low throughout each conversion.
REQ-036 cmd ch9 -> rsp at T+1, data 0, ch9, adc_cs_n never low; next ch0 needs no priming.
REQ-037 reset_n low during SHIFT bit 7 -> adc_cs_n/adc_sclk high same cycle, no rsp_valid; then cmd ch3 -> primed, rsp at T+273.
REQ-038 CLK_DIV=1, cmd ch0 after reset -> SCLK period 2 clk, rsp at T+35, data matches model.
